// File: rtl/cnn_pkg.sv
// Shared definitions for the 4x4 CNN grid engine and its output streamer.
package cnn_pkg;
  localparam int WIDTH = 9;
  localparam int CELLS = 16;

  typedef enum logic {IDLE, STREAM} state_e;

  // Cell k (0-based) state from the flattened grid bus.
  function automatic logic [2*WIDTH-1:0] y_slice(input logic [CELLS*2*WIDTH-1:0] y,
                                                 input logic [3:0] k);
    return y[k*2*WIDTH +: 2*WIDTH];
  endfunction
endpackage

// File: rtl/cnn_grid_streamer_if.sv
// Sample stream from the grid streamer to the host-side reader.
interface cnn_grid_streamer_if #(parameter int OUT_W = 9);
  logic                    m_valid;
  logic                    m_ready;
  logic signed [OUT_W-1:0] m_data;
  logic [3:0]              m_index;
  logic                    m_first;
  logic                    m_last;

  modport master (output m_valid, m_data, m_index, m_first, m_last, input m_ready);
  modport slave  (input m_valid, m_data, m_index, m_first, m_last, output m_ready);
endinterface

// File: rtl/cnn_sat_shift.sv
// Arithmetic right shift (floor) followed by clamp to a signed OUT_W range.
module cnn_sat_shift #(
  parameter int IN_W       = 18,
  parameter int OUT_W      = 9,
  parameter int FRAC_SHIFT = 0
) (
  input  logic signed [IN_W-1:0]  v_i,
  output logic signed [OUT_W-1:0] s_o
);
  // One guard bit above the wider operand keeps the compare range exact.
  localparam int EW = ((IN_W > OUT_W) ? IN_W : OUT_W) + 1;
  localparam logic signed [EW-1:0] MAX_V = {{(EW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = {{(EW-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [IN_W-1:0] sh;
  logic signed [EW-1:0]   s_ext;

  assign sh    = v_i >>> FRAC_SHIFT;
  assign s_ext = EW'(sh);

  always_comb begin
    s_o = s_ext[OUT_W-1:0];
    if (s_ext > MAX_V)      s_o = MAX_V[OUT_W-1:0];
    else if (s_ext < MIN_V) s_o = MIN_V[OUT_W-1:0];
  end
endmodule

// File: rtl/cnn_grid_streamer.sv
// Snapshots the 16 grid cell states on a strobe and streams them, scaled and
// saturated, in raster order over a valid/ready port.
module cnn_grid_streamer #(
  parameter int WIDTH      = cnn_pkg::WIDTH,
  parameter int OUT_W      = 9,
  parameter int FRAC_SHIFT = 0
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic [cnn_pkg::CELLS*2*WIDTH-1:0]   y_flat,
  input  logic                                snap,
  input  logic                                clear_ovr,
  cnn_grid_streamer_if.master                 m,
  output logic                                busy,
  output logic                                overrun
);
  import cnn_pkg::*;

  localparam int SW = 2*WIDTH;

  state_e                   state_q, state_d;
  logic [3:0]               idx_q, idx_d;
  logic                     overrun_q, overrun_d;
  logic [CELLS-1:0][SW-1:0] buf_q, buf_d;

  logic                     streaming, beat, last_beat, accept, drop;
  logic signed [OUT_W-1:0]  sat_data;

  assign streaming = (state_q == STREAM);
  assign beat      = streaming & m.m_ready;
  assign last_beat = beat & (idx_q == 4'd15);
  // The final beat frees the buffer, so a snap on that cycle chains a new frame.
  assign accept    = snap & (~streaming | last_beat);
  assign drop      = snap & streaming & ~last_beat;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        idx_d = 4'd0;
        if (snap) state_d = STREAM;
      end
      STREAM: begin
        if (beat)                 idx_d   = idx_q + 4'd1;
        if (last_beat && !snap)   state_d = IDLE;
      end
    endcase
    if (accept) buf_d = y_flat;
    if (drop)           overrun_d = 1'b1;
    else if (clear_ovr) overrun_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 4'd0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  cnn_sat_shift #(.IN_W(SW), .OUT_W(OUT_W), .FRAC_SHIFT(FRAC_SHIFT)) u_sat (
    .v_i (buf_q[idx_q]),
    .s_o (sat_data)
  );

  // Output is combinational off the held buffer/index, so it is stable under stall.
  assign m.m_valid = streaming;
  assign m.m_data  = streaming ? sat_data : '0;
  assign m.m_index = idx_q;
  assign m.m_first = streaming & (idx_q == 4'd0);
  assign m.m_last  = streaming & (idx_q == 4'd15);
  assign busy      = streaming;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_cnn_grid_streamer.sv
// Scoreboard bench for cnn_grid_streamer: directed frames, FRAC_SHIFT 0 and 2 instances.
module tb_cnn_grid_streamer;
  localparam int SW = 18;

  typedef struct { int data; int idx; } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [16*SW-1:0] y_flat = '0;
  logic snap = 1'b0, snap2 = 1'b0, clear_ovr = 1'b0;
  logic busy0, ovr0, busy2, ovr2;

  int checks = 0, failures = 0, beats = 0, beats2 = 0;
  exp_t q0[$], q2[$];

  cnn_grid_streamer_if #(.OUT_W(9)) bus0();
  cnn_grid_streamer_if #(.OUT_W(9)) bus2();

  cnn_grid_streamer #(.WIDTH(9), .OUT_W(9), .FRAC_SHIFT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .y_flat(y_flat), .snap(snap), .clear_ovr(clear_ovr),
    .m(bus0), .busy(busy0), .overrun(ovr0));

  cnn_grid_streamer #(.WIDTH(9), .OUT_W(9), .FRAC_SHIFT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .y_flat(y_flat), .snap(snap2), .clear_ovr(clear_ovr),
    .m(bus2), .busy(busy2), .overrun(ovr2));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_y(input int v[16]);
    for (int i = 0; i < 16; i++) y_flat[i*SW +: SW] = SW'(v[i]);
  endtask

  task automatic push0(input int e[16]);
    for (int i = 0; i < 16; i++) q0.push_back('{e[i], i});
  endtask

  task automatic wait_idle0(input int maxc);
    int n = 0;
    while (busy0 && n < maxc) begin step(); n++; end
    chk("idle0_timeout", busy0, 0);
  endtask

  // Monitor for dut0: scoreboard pop on beat, hold check under backpressure.
  initial begin
    logic stall = 1'b0;
    int hold_data = 0, hold_idx = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (stall) begin
          chk("stall_valid", bus0.m_valid, 1);
          chk("stall_data", $signed(bus0.m_data), hold_data);
          chk("stall_idx", bus0.m_index, hold_idx);
        end
        stall     = bus0.m_valid && !bus0.m_ready;
        hold_data = $signed(bus0.m_data);
        hold_idx  = bus0.m_index;
        if (bus0.m_valid && bus0.m_ready) begin
          exp_t e;
          beats++;
          chk("beat_expected", q0.size() > 0, 1);
          if (q0.size() > 0) begin
            e = q0.pop_front();
            chk("data", $signed(bus0.m_data), e.data);
            chk("index", bus0.m_index, e.idx);
            chk("first", bus0.m_first, e.idx == 0);
            chk("last", bus0.m_last, e.idx == 15);
          end
        end
      end else stall = 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus2.m_valid && bus2.m_ready) begin
        exp_t e;
        beats2++;
        chk("beat2_expected", q2.size() > 0, 1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          chk("data2", $signed(bus2.m_data), e.data);
          chk("index2", bus2.m_index, e.idx);
        end
      end
    end
  end

  initial begin
    int v[16], e[16], alt[16];
    bus0.m_ready = 1'b1;
    bus2.m_ready = 1'b1;

    // Reset state
    repeat (2) step();
    chk("rst_valid", bus0.m_valid, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_overrun", ovr0, 0);
    chk("rst_index", bus0.m_index, 0);
    chk("rst_data", $signed(bus0.m_data), 0);
    rst_n = 1'b1;
    step();

    // 1: ramp 0,10,...,150 at full rate
    for (int i = 0; i < 16; i++) v[i] = 10*i;
    load_y(v); push0(v); snap = 1'b1;
    step(); snap = 1'b0;
    chk("t1_latency_valid", bus0.m_valid, 1);
    chk("t1_first_idx", bus0.m_index, 0);
    repeat (15) step();
    chk("t1_busy_at_last", busy0, 1);
    chk("t1_last_idx", bus0.m_index, 15);
    step();
    chk("t1_busy_after", busy0, 0);
    chk("t1_valid_after", bus0.m_valid, 0);

    // 2a: saturation, FRAC_SHIFT=0
    v = '{300, -300, 255, 256, -256, -257, 1, -1, 0, 0, 0, 0, 0, 0, 0, 0};
    e = '{255, -256, 255, 255, -256, -256, 1, -1, 0, 0, 0, 0, 0, 0, 0, 0};
    load_y(v); push0(e); snap = 1'b1;
    step(); snap = 1'b0;
    wait_idle0(40);

    // 2b: FRAC_SHIFT=2, floor toward -inf then clamp
    v = '{-5, 7, -1, 1023, 1024, -1028, -1024, 3, -4, 8, -8, 0, 0, 0, 0, 0};
    e = '{-2, 1, -1, 255, 255, -256, -256, 0, -1, 2, -2, 0, 0, 0, 0, 0};
    load_y(v);
    for (int i = 0; i < 16; i++) q2.push_back('{e[i], i});
    snap2 = 1'b1;
    step(); snap2 = 1'b0;
    begin
      int n = 0;
      while (busy2 && n < 40) begin step(); n++; end
      chk("idle2_timeout", busy2, 0);
    end
    chk("t2_beats2", beats2, 16);

    // 3: ready pattern 1,0,0 repeating
    for (int i = 0; i < 16; i++) v[i] = 3*i - 20;
    load_y(v); push0(v); snap = 1'b1;
    step(); snap = 1'b0;
    beats = 0;
    for (int c = 0; c < 80 && busy0; c++) begin
      bus0.m_ready = (c % 3 == 0);
      step();
    end
    bus0.m_ready = 1'b1;
    chk("t3_done", busy0, 0);
    chk("t3_beats", beats, 16);

    // 4: snap at idx 5 is dropped; clear_ovr on the same cycle loses to the set
    for (int i = 0; i < 16; i++) begin v[i] = 7*i + 1; alt[i] = 200 - i; end
    load_y(v); push0(v); snap = 1'b1;
    step(); snap = 1'b0;
    repeat (5) step();
    chk("t4_at_idx5", bus0.m_index, 5);
    load_y(alt); snap = 1'b1; clear_ovr = 1'b1;
    step(); snap = 1'b0; clear_ovr = 1'b0;
    chk("t4_overrun_set", ovr0, 1);
    chk("t4_idx_advanced", bus0.m_index, 6);
    wait_idle0(40);
    chk("t4_overrun_sticky", ovr0, 1);
    clear_ovr = 1'b1;
    step(); clear_ovr = 1'b0;
    chk("t4_overrun_cleared", ovr0, 0);

    // 5: snap coinciding with the idx-15 beat chains a new frame
    for (int i = 0; i < 16; i++) begin v[i] = 100 + i; e[i] = -5*(i+1); end
    load_y(v); push0(v); snap = 1'b1;
    step(); snap = 1'b0;
    repeat (15) step();
    chk("t5_at_idx15", bus0.m_index, 15);
    load_y(e); push0(e); snap = 1'b1;
    step(); snap = 1'b0;
    chk("t5_valid", bus0.m_valid, 1);
    chk("t5_idx0", bus0.m_index, 0);
    chk("t5_data", $signed(bus0.m_data), -5);
    chk("t5_no_overrun", ovr0, 0);
    wait_idle0(40);

    // 6: reset mid-frame aborts; fresh frame streams fully
    for (int i = 0; i < 16; i++) v[i] = i;
    load_y(v); push0(v); snap = 1'b1;
    step(); snap = 1'b0;
    repeat (3) step();
    snap = 1'b1;
    step(); snap = 1'b0;
    chk("t6_overrun_pre", ovr0, 1);
    repeat (3) step();
    chk("t6_at_idx7", bus0.m_index, 7);
    rst_n = 1'b0;
    step();
    chk("t6_valid", bus0.m_valid, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_overrun", ovr0, 0);
    chk("t6_index", bus0.m_index, 0);
    chk("t6_data", $signed(bus0.m_data), 0);
    q0.delete();
    rst_n = 1'b1;
    step();
    beats = 0;
    for (int i = 0; i < 16; i++) v[i] = -16*i;
    load_y(v); push0(v); snap = 1'b1;
    step(); snap = 1'b0;
    wait_idle0(40);
    chk("t6_beats", beats, 16);

    step();
    chk("q0_drained", q0.size(), 0);
    chk("q2_drained", q2.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
